// File: rtl/popcnt_rr_sched_if.sv
// Bus between the requesters and the shared popcount engine.
// master: the producer side (drives req/req_data, sees grants and results).
// slave : the popcnt_rr_sched engine.
interface popcnt_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [CW-1:0]         res_count;
  logic [IW-1:0]         res_id;

  modport master (
    output req, req_data,
    input  gnt, busy, res_valid, res_count, res_id
  );

  modport slave (
    input  req, req_data,
    output gnt, busy, res_valid, res_count, res_id
  );
endinterface

// File: rtl/popcnt_rr_sched.sv
// popcnt_rr_sched: one serial ones-counter shared by NREQ requesters under
// round-robin arbitration. A granted word is shifted out LSB first, one bit
// per clock, and the count is returned tagged with the requester index.
// Optional macro POPCNT_EARLY_EXIT_EN: stop counting as soon as the bits not
// yet processed are all zero (same results, shorter latency).
module popcnt_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  popcnt_rr_sched_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NREQ);
  localparam int XW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]   acc, acc_next;
  logic [XW-1:0]   idx, idx_next;
  logic [IW-1:0]   last_id, last_id_next;
  logic [NREQ-1:0] gnt_val, gnt_next;
  logic            valid_val, valid_next;
  logic [CW-1:0]   count_val, count_next;
  logic [IW-1:0]   id_val, id_next;

  logic             any_req;
  logic [IW-1:0]    winner;
  logic [WIDTH-1:0] win_word;
  logic             last_bit;

  // Round-robin search starting just after the previous winner, so the most
  // recently served requester always ranks lowest.
  always_comb begin
    any_req  = 1'b0;
    winner   = last_id;
    for (int off = 1; off <= NREQ; off++) begin
      int cand;
      cand = int'(last_id) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        winner  = IW'(cand);
      end
    end
    win_word = bus.req_data[int'(winner)*WIDTH +: WIDTH];
  end

  // The count ends on the final bit position, or earlier when nothing but
  // zeros remains above the bit being consumed this cycle.
`ifdef POPCNT_EARLY_EXIT_EN
  assign last_bit = (idx == XW'(WIDTH-1)) || (shreg[WIDTH-1:1] == '0);
`else
  assign last_bit = (idx == XW'(WIDTH-1));
`endif

  // Next-state and datapath: IDLE and DONE both arbitrate, COUNT consumes bits.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    acc_next     = acc;
    idx_next     = idx;
    last_id_next = last_id;
    gnt_next     = '0;
    valid_next   = 1'b0;
    count_next   = count_val;
    id_next      = id_val;
    case (state)
      IDLE, DONE: begin
        if (any_req) begin
          shreg_next       = win_word;
          acc_next         = '0;
          idx_next         = '0;
          last_id_next     = winner;
          gnt_next[winner] = 1'b1;
          state_next       = COUNT;
        end else begin
          state_next = IDLE;
        end
      end
      COUNT: begin
        acc_next   = acc + CW'(shreg[0]);
        shreg_next = shreg >> 1;
        idx_next   = idx + XW'(1);
        if (last_bit) begin
          state_next = DONE;
          valid_next = 1'b1;
          count_next = acc + CW'(shreg[0]);
          id_next    = last_id;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any partial count on the spot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      idx       <= '0;
      last_id   <= IW'(NREQ-1);
      gnt_val   <= '0;
      valid_val <= 1'b0;
      count_val <= '0;
      id_val    <= '0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      acc       <= acc_next;
      idx       <= idx_next;
      last_id   <= last_id_next;
      gnt_val   <= gnt_next;
      valid_val <= valid_next;
      count_val <= count_next;
      id_val    <= id_next;
    end
  end

  assign bus.gnt       = gnt_val;
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = valid_val;
  assign bus.res_count = count_val;
  assign bus.res_id    = id_val;

endmodule

// File: tb/tb_popcnt_rr_sched.sv
// Directed testbench for popcnt_rr_sched (NREQ=4, WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_popcnt_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int TMO   = 60;

`ifdef POPCNT_EARLY_EXIT_EN
  localparam int LAT_SINGLE = 11;               // 10 COUNT cycles + 1
  localparam int LEN0 = 16, LEN1 = 1, LEN2 = 16, LEN3 = 8;
`else
  localparam int LAT_SINGLE = 17;
  localparam int LEN0 = 16, LEN1 = 16, LEN2 = 16, LEN3 = 16;
`endif

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  popcnt_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  popcnt_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    bus.req_data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < TMO);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < TMO);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.req = '0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #10;
    total++;
    if ({bus.gnt, bus.busy, bus.res_valid, bus.res_count, bus.res_id} !== '0)
      $display("FAIL reset_outputs: got gnt=%b busy=%b valid=%b count=%0d id=%0d, want all 0",
               bus.gnt, bus.busy, bus.res_valid, bus.res_count, bus.res_id);
    else passed++;
    reset_n = 1'b1;
    $display("reset: gnt=%b busy=%b", bus.gnt, bus.busy);
  endtask

  task automatic test_single();
    int n;
    @(negedge clk);
    set_word(0, 16'b0000001111110010);
    bus.req = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1)
      $display("FAIL single_gnt: got gnt=%b busy=%b, want 0001 1", bus.gnt, bus.busy);
    else passed++;
    bus.req = '0;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0000)
      $display("FAIL single_gnt_pulse: got gnt=%b, want 0000", bus.gnt);
    else passed++;
    wait_valid(n);
    n = n + 2;
    total++;
    if (n !== LAT_SINGLE || bus.res_count !== 5'd7 || bus.res_id !== 2'd0)
      $display("FAIL single_result: got lat=%0d count=%0d id=%0d, want %0d 7 0",
               n, bus.res_count, bus.res_id, LAT_SINGLE);
    else passed++;
    $display("single: lat=%0d count=%0d id=%0d", n, bus.res_count, bus.res_id);
    @(negedge clk);
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_count !== 5'd7)
      $display("FAIL single_after: got valid=%b busy=%b count=%0d, want 0 0 7",
               bus.res_valid, bus.busy, bus.res_count);
    else passed++;
  endtask

  task automatic test_all_four();
    int n;
    int lens [4];
    logic [4:0] cnts [4];
    lens = '{LEN0, LEN1, LEN2, LEN3};
    cnts = '{5'd16, 5'd0, 5'd2, 5'd4};
    pulse_reset();
    set_word(0, 16'hFFFF);
    set_word(1, 16'h0000);
    set_word(2, 16'h8001);
    set_word(3, 16'h00F0);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(n);
      total++;
      if (bus.gnt !== 4'(1 << i) || (i > 0 && n !== 1))
        $display("FAIL b2b_gnt%0d: got gnt=%b wait=%0d, want %b wait 1",
                 i, bus.gnt, n, 4'(1 << i));
      else passed++;
      bus.req[i] = 1'b0;
      wait_valid(n);
      total++;
      if (n !== lens[i] || bus.res_count !== cnts[i] || bus.res_id !== 2'(i))
        $display("FAIL b2b_res%0d: got len=%0d count=%0d id=%0d, want %0d %0d %0d",
                 i, n, bus.res_count, bus.res_id, lens[i], cnts[i], i);
      else passed++;
      $display("b2b: req %0d count=%0d id=%0d len=%0d", i, bus.res_count, bus.res_id, n);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000)
      $display("FAIL b2b_idle: got busy=%b gnt=%b, want 0 0000", bus.busy, bus.gnt);
    else passed++;
  endtask

  task automatic test_rr_wrap();
    int n;
    logic [3:0] exp_g [3];
    logic [4:0] exp_c [3];
    exp_g = '{4'b0100, 4'b1000, 4'b0100};
    exp_c = '{5'd2, 5'd3, 5'd2};
    set_word(2, 16'h0003);
    set_word(3, 16'h0700);
    bus.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(n);
      total++;
      if (bus.gnt !== exp_g[k])
        $display("FAIL rr_gnt%0d: got %b, want %b", k, bus.gnt, exp_g[k]);
      else passed++;
      if (k == 0) bus.req = 4'b1100;
      if (k == 2) bus.req = 4'b0000;
      wait_valid(n);
      total++;
      if (bus.res_count !== exp_c[k] || bus.res_id !== (exp_g[k] == 4'b0100 ? 2'd2 : 2'd3))
        $display("FAIL rr_res%0d: got count=%0d id=%0d, want %0d", k,
                 bus.res_count, bus.res_id, exp_c[k]);
      else passed++;
      $display("rr: grant %b count=%0d id=%0d", exp_g[k], bus.res_count, bus.res_id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    set_word(1, 16'hFFFF);
    bus.req = 4'b0010;
    wait_gnt(n);
    total++;
    if (bus.gnt !== 4'b0010)
      $display("FAIL mid_gnt: got %b, want 0010", bus.gnt);
    else passed++;
    bus.req = '0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.busy, bus.res_valid, bus.res_count, bus.res_id} !== '0)
      $display("FAIL mid_reset_outputs: got busy=%b valid=%b count=%0d id=%0d, want all 0",
               bus.busy, bus.res_valid, bus.res_count, bus.res_id);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL mid_no_result: got %0d active cycles after reset, want 0", seen);
    else passed++;
    set_word(0, 16'h0F0F);
    set_word(3, 16'h0001);
    bus.req = 4'b1001;
    wait_gnt(n);
    total++;
    if (bus.gnt !== 4'b0001)
      $display("FAIL mid_first_gnt: got %b, want 0001", bus.gnt);
    else passed++;
    bus.req = '0;
    wait_valid(n);
    total++;
    if (bus.res_count !== 5'd8 || bus.res_id !== 2'd0)
      $display("FAIL mid_result: got count=%0d id=%0d, want 8 0", bus.res_count, bus.res_id);
    else passed++;
    $display("reset_mid: post-reset grant to 0, count=%0d", bus.res_count);
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    int n;
    int extra;
    set_word(1, 16'h00FF);
    set_word(2, 16'hFFFF);
    bus.req = 4'b0010;
    wait_gnt(n);
    total++;
    if (bus.gnt !== 4'b0010)
      $display("FAIL wd_gnt: got %b, want 0010", bus.gnt);
    else passed++;
    bus.req = '0;
    extra = 0;
    repeat (2) @(negedge clk);
    bus.req[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.gnt != '0) extra++;
    end
    bus.req[2] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.gnt != '0) extra++;
    end while (!bus.res_valid && n < TMO);
    total++;
    if (bus.res_valid !== 1'b1 || bus.res_count !== 5'd8 || bus.res_id !== 2'd1)
      $display("FAIL wd_result: got valid=%b count=%0d id=%0d, want 1 8 1",
               bus.res_valid, bus.res_count, bus.res_id);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      if (bus.gnt != '0) extra++;
    end
    total++;
    if (extra !== 0 || bus.busy !== 1'b0)
      $display("FAIL wd_no_grant: got extra grants=%0d busy=%b, want 0 0", extra, bus.busy);
    else passed++;
    $display("withdraw: extra grants=%0d busy=%b", extra, bus.busy);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_all_four();
    test_rr_wrap();
    test_reset_mid();
    test_withdraw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
